wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back end of the MEM/WB interface. Consumes wb_dstE/wb_valE/wb_dstM/wb_valM
//  and commits them into the 8-entry Y86 program register file on the clock edge.
//  Provides two read ports (srcA/srcB) to decode.
//  Keeps a retired-write counter for debug and performance monitoring.
// PARAMETERS
//  NREGS      8     number of architectural registers (ids 0..NREGS-1; eax..edi)
//  RNONE      8'hF  register id meaning "no register"
//  CNT_W      32    width of wr_count
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst        in   1      asynchronous, active-low reset
//  W_stall_i  in   1      1 = hold W stage; no register write, no count
//  wb_dstE    in   8      E-port destination id (RNONE = no write)
//  wb_valE    in   32     E-port write data
//  wb_dstM    in   8      M-port destination id (RNONE = no write)
//  wb_valM    in   32     M-port write data
//  d_srcA     in   8      read port A id
//  d_srcB     in   8      read port B id
//  d_rvalA    out  32     read data A
//  d_rvalB    out  32     read data B
//  wr_count   out  CNT_W  number of register writes committed since reset
// BEHAVIOUR
//  Reset (rst=0, async): all registers 0, wr_count 0; holds while rst=0.
//   A write pending at reset assertion is dropped.
//  Write enables:
//   weE = !W_stall_i && wb_dstE < NREGS
//   weM = !W_stall_i && wb_dstM < NREGS
//   Ids >= NREGS, including RNONE, never write.
//  Commit: on posedge clk, reg[wb_dstE] <= wb_valE if weE, and reg[wb_dstM] <= wb_valM if weM.
//  Same-id conflict: if weE && weM && wb_dstE==wb_dstM, valM wins (popl %esp rule).
//   wr_count increments by 1, not 2.
//  wr_count: on each posedge, += (weE + weM - conflict).
//   Modulo 2^CNT_W; wraps all-ones -> 0 silently.
//  Reads are combinational, with one cycle of latency to visibility of a write.
//   d_rvalX = reg[d_srcX] if d_srcX < NREGS, else 32'h0 (RNONE reads 0).
//  Stall: with W_stall_i=1, all registers and wr_count hold.
//   The upstream MEM/WB values are expected stable.
//  No internal FSM. State is the register array plus the counter; the inputs are not registered here.
// CONFIGURATION
//  `REGFILE_BYPASS_EN defined: write-through forwarding on both read ports.
//   If d_srcX < NREGS and matches an enabled write in the same cycle, d_rvalX returns the incoming data.
//   Priority: M-port match (valM) over E-port match (valE) over the array.
//   A stalled write (W_stall_i=1) is not forwarded.
//  Undefined: no forwarding; a same-cycle read returns the old array value.
//   The new value is visible the cycle after the edge.
// TESTING
//  1 Reset: rst=0 mid-run after writing eax=5 -> all d_rval 0, wr_count 0. Release -> still 0.
//  2 Single write: dstE=0 valE=32'h1234, dstM=F, srcA=0.
//    Next cycle d_rvalA=32'h1234, wr_count=1. The RNONE port causes no write.
//  3 Dual/conflict: dstE=4 valE=0x10, dstM=4 valM=0x20 -> reg4=0x20, wr_count+1.
//    dstE=1, dstM=2 -> both written, wr_count+2.
//  4 Stall: W_stall_i=1, dstE=3 valE=0xAA -> reg3 and wr_count unchanged.
//    Deassert with the same inputs -> reg3=0xAA, count+1.
//  5 Bypass: srcA=srcB=5, dstE=5 valE=7, dstM=5 valM=9 in the same cycle.
//    With REGFILE_BYPASS_EN: d_rvalA=d_rvalB=9 that cycle.
//    Without: both show the old value (0), then 9 next cycle.
//  6 Wrap and bad ids: force wr_count=32'hFFFFFFFF, do one write -> 0.
//    dstE=8'h08 or 8'h0F -> no write. srcA=8'h09 -> d_rvalA=0.

Source files
------------

// File: rtl/wb_regfile.sv
// Y86 write-back register file: 8x32 array, two combinational read ports, E/M commit ports (M wins on same id), retired-write counter.
// Writes land on posedge and are visible the next cycle; W_stall_i holds all state. `REGFILE_BYPASS_EN adds same-cycle write-through forwarding.
module wb_regfile #(
    parameter int         NREGS = 8,
    parameter logic [7:0] RNONE = 8'hF,
    parameter int         CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             W_stall_i,
    input  logic [7:0]       wb_dstE,
    input  logic [31:0]      wb_valE,
    input  logic [7:0]       wb_dstM,
    input  logic [31:0]      wb_valM,
    input  logic [7:0]       d_srcA,
    input  logic [7:0]       d_srcB,
    output logic [31:0]      d_rvalA,
    output logic [31:0]      d_rvalB,
    output logic [CNT_W-1:0] wr_count
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [31:0]   regs [NREGS];
    logic          we_e;
    logic          we_m;
    logic          conflict;
    logic [1:0]    inc;
    logic [IW-1:0] idx_e;
    logic [IW-1:0] idx_m;
    logic [IW-1:0] idx_a;
    logic [IW-1:0] idx_b;

    assign idx_e = wb_dstE[IW-1:0];
    assign idx_m = wb_dstM[IW-1:0];
    assign idx_a = d_srcA[IW-1:0];
    assign idx_b = d_srcB[IW-1:0];

    // RNONE is already out of range for NREGS<=15; kept explicit in case NREGS grows.
    assign we_e     = !W_stall_i && (wb_dstE < 8'(NREGS)) && (wb_dstE != RNONE);
    assign we_m     = !W_stall_i && (wb_dstM < 8'(NREGS)) && (wb_dstM != RNONE);
    assign conflict = we_e && we_m && (wb_dstE == wb_dstM);

    always_comb begin
        inc = 2'd0;
        if (we_e && we_m && !conflict) begin
            inc = 2'd2;
        end else if (we_e || we_m) begin
            inc = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else begin
            if (we_e) begin
                regs[idx_e] <= wb_valE;
            end
            // M is written last so it wins a same-id conflict (popl %esp).
            if (we_m) begin
                regs[idx_m] <= wb_valM;
            end
            wr_count <= wr_count + CNT_W'(inc);
        end
    end

    always_comb begin
        d_rvalA = '0;
        d_rvalB = '0;
        if (d_srcA < 8'(NREGS)) begin
            d_rvalA = regs[idx_a];
`ifdef REGFILE_BYPASS_EN
            if (we_m && (wb_dstM == d_srcA)) begin
                d_rvalA = wb_valM;
            end else if (we_e && (wb_dstE == d_srcA)) begin
                d_rvalA = wb_valE;
            end
`endif
        end
        if (d_srcB < 8'(NREGS)) begin
            d_rvalB = regs[idx_b];
`ifdef REGFILE_BYPASS_EN
            if (we_m && (wb_dstM == d_srcB)) begin
                d_rvalB = wb_valM;
            end else if (we_e && (wb_dstE == d_srcB)) begin
                d_rvalB = wb_valE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; a second instance with a 3-bit counter exercises counter wrap.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        W_stall_i;
    logic [7:0]  wb_dstE;
    logic [31:0] wb_valE;
    logic [7:0]  wb_dstM;
    logic [31:0] wb_valM;
    logic [7:0]  d_srcA;
    logic [7:0]  d_srcB;
    logic [31:0] d_rvalA;
    logic [31:0] d_rvalB;
    logic [31:0] wr_count;
    logic [31:0] s_rvalA;
    logic [31:0] s_rvalB;
    logic [2:0]  s_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst), .W_stall_i(W_stall_i),
        .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
        .wr_count(wr_count)
    );

    wb_regfile #(.CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .W_stall_i(W_stall_i),
        .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(s_rvalA), .d_rvalB(s_rvalB),
        .wr_count(s_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        W_stall_i = 1'b0;
        wb_dstE   = 8'h0F;
        wb_valE   = 32'h0;
        wb_dstM   = 8'h0F;
        wb_valM   = 32'h0;
    endtask

    initial begin
        rst    = 1'b0;
        idle();
        d_srcA = 8'h00;
        d_srcB = 8'h00;
        tick();
        tick();
        chk("reset_rvalA", d_rvalA, 32'h0);
        chk("reset_count", wr_count, 32'h0);
        rst = 1'b1;
        tick();

        // write eax=5, then async reset mid-cycle with a write pending
        wb_dstE = 8'h00; wb_valE = 32'h5;
        tick();
        idle();
        chk("pre_reset_eax", d_rvalA, 32'h5);
        chk("pre_reset_count", wr_count, 32'h1);
        wb_dstE = 8'h00; wb_valE = 32'h77;
        #2 rst = 1'b0;
        #1;
        chk("async_reset_eax", d_rvalA, 32'h0);
        chk("async_reset_count", wr_count, 32'h0);
        tick();
        chk("reset_hold_eax", d_rvalA, 32'h0);
        idle();
        rst = 1'b1;
        tick();
        chk("release_eax", d_rvalA, 32'h0);
        chk("release_count", wr_count, 32'h0);

        // single write, M port RNONE
        wb_dstE = 8'h00; wb_valE = 32'h1234;
        tick();
        idle();
        chk("single_eax", d_rvalA, 32'h1234);
        chk("single_count", wr_count, 32'h1);
        d_srcA = 8'h0F;
        #1 chk("rnone_read", d_rvalA, 32'h0);

        // same-id conflict: M wins, count +1
        wb_dstE = 8'h04; wb_valE = 32'h10; wb_dstM = 8'h04; wb_valM = 32'h20;
        tick();
        idle();
        d_srcA = 8'h04;
        #1 chk("conflict_reg4", d_rvalA, 32'h20);
        chk("conflict_count", wr_count, 32'h2);

        // dual write to distinct ids, count +2
        wb_dstE = 8'h01; wb_valE = 32'h11; wb_dstM = 8'h02; wb_valM = 32'h22;
        tick();
        idle();
        d_srcA = 8'h01; d_srcB = 8'h02;
        #1 chk("dual_reg1", d_rvalA, 32'h11);
        chk("dual_reg2", d_rvalB, 32'h22);
        chk("dual_count", wr_count, 32'h4);

        // stall holds, release commits
        W_stall_i = 1'b1; wb_dstE = 8'h03; wb_valE = 32'hAA;
        d_srcA = 8'h03;
        tick();
        chk("stall_reg3", d_rvalA, 32'h0);
        chk("stall_count", wr_count, 32'h4);
        W_stall_i = 1'b0;
        tick();
        idle();
        chk("unstall_reg3", d_rvalA, 32'hAA);
        chk("unstall_count", wr_count, 32'h5);

        // same-cycle read of a dual write to reg5 (M priority when forwarded)
        d_srcA = 8'h05; d_srcB = 8'h05;
        wb_dstE = 8'h05; wb_valE = 32'h7; wb_dstM = 8'h05; wb_valM = 32'h9;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_a_same", d_rvalA, 32'h9);
        chk("bypass_b_same", d_rvalB, 32'h9);
`else
        chk("nobypass_a_same", d_rvalA, 32'h0);
        chk("nobypass_b_same", d_rvalB, 32'h0);
`endif
        tick();
        idle();
        chk("reg5_a_next", d_rvalA, 32'h9);
        chk("reg5_b_next", d_rvalB, 32'h9);
        chk("reg5_count", wr_count, 32'h6);

        // per-port forwarding: A sees E-port, B sees M-port
        d_srcA = 8'h06; d_srcB = 8'h07;
        wb_dstE = 8'h06; wb_valE = 32'h66; wb_dstM = 8'h07; wb_valM = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_e_port", d_rvalA, 32'h66);
        chk("bypass_m_port", d_rvalB, 32'h77);
`else
        chk("nobypass_e_port", d_rvalA, 32'h0);
        chk("nobypass_m_port", d_rvalB, 32'h0);
`endif
        tick();
        idle();
        chk("reg6_next", d_rvalA, 32'h66);
        chk("reg7_next", d_rvalB, 32'h77);
        chk("reg67_count", wr_count, 32'h8);
        chk("small_count_wrap8", {29'h0, s_count}, 32'h0);

        // out-of-range destinations never write (id 8 must not alias reg 0)
        wb_dstE = 8'h08; wb_valE = 32'hBAD; wb_dstM = 8'h10; wb_valM = 32'hBEEF;
        tick();
        wb_dstE = 8'h0F; wb_valE = 32'hBAD;
        tick();
        idle();
        chk("bad_id_count", wr_count, 32'h8);
        d_srcA = 8'h00; d_srcB = 8'h09;
        #1 chk("bad_id_reg0", d_rvalA, 32'h1234);
        chk("read_id9", d_rvalB, 32'h0);

        // wrap: 3-bit counter goes 0 -> 7 -> 0
        for (int i = 0; i < 7; i++) begin
            wb_dstE = 8'(i); wb_valE = 32'(i + 100);
            tick();
        end
        idle();
        chk("small_count_7", {29'h0, s_count}, 32'h7);
        chk("count_15", wr_count, 32'd15);
        wb_dstM = 8'h02; wb_valM = 32'h222;
        tick();
        idle();
        chk("small_count_wrap", {29'h0, s_count}, 32'h0);
        chk("count_16", wr_count, 32'd16);
        d_srcA = 8'h02;
        #1 chk("wrap_reg2", d_rvalA, 32'h222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
